// File: rtl/divide_issue_stage.sv
// Operand-issue / result-capture stage around an external combinational divider.
// A 2-entry FIFO feeds abus/bbus, which are held SETTLE cycles before div_out is captured.
module divide_issue_stage #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus,
    input  logic [WIDTH-1:0] div_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_q,
    output logic             res_dz,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and res_* stay stable while res_valid && !res_ready.

    localparam int CW = $clog2(SETTLE) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] abus_q, abus_d;
    logic [WIDTH-1:0] bbus_q, bbus_d;
    logic [WIDTH-1:0] res_q_q, res_q_d;
    logic             res_dz_q, res_dz_d;
    logic             res_valid_q, res_valid_d;

    logic [WIDTH-1:0] fifo_a_q [2];
    logic [WIDTH-1:0] fifo_b_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full     = (count_q == 2'd2);
        empty    = (count_q == 2'd0);
        in_ready = rst_n && !full;
        push     = in_valid && in_ready;
        pop      = (state_q == S_IDLE) && !empty;
    end

    // FIFO pointer/occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abus_d      = abus_q;
        bbus_d      = bbus_q;
        res_q_d     = res_q_q;
        res_dz_d    = res_dz_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    abus_d  = fifo_a_q[rd_ptr_q];
                    bbus_d  = fifo_b_q[rd_ptr_q];
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // A zero divisor never trusts div_out.
                    res_q_d     = (bbus_q == '0) ? {WIDTH{1'b1}} : div_out;
                    res_dz_d    = (bbus_q == '0);
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            abus_q      <= '0;
            bbus_q      <= '0;
            res_q_q     <= '0;
            res_dz_q    <= 1'b0;
            res_valid_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abus_q      <= abus_d;
            bbus_q      <= bbus_d;
            res_q_q     <= res_q_d;
            res_dz_q    <= res_dz_d;
            res_valid_q <= res_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= in_a;
            fifo_b_q[wr_ptr_q] <= in_b;
        end
    end

    assign abus        = abus_q;
    assign bbus        = bbus_q;
    assign res_q       = res_q_q;
    assign res_dz      = res_dz_q;
    assign res_valid   = res_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divide_issue_stage.sv
// Directed bench for divide_issue_stage: WIDTH=8/SETTLE=2 instance plus a WIDTH=1/SETTLE=1 instance.
module tb_divide_issue_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8, SETTLE=2 instance
    logic       in_valid, in_ready, res_valid, res_ready, res_dz;
    logic [7:0] in_a, in_b, abus, bbus, div_out, res_q;
    logic [1:0] dbg_state;

    // The bench plays the divider; a junk value on divide-by-zero proves it is ignored.
    assign div_out = (bbus != 8'd0) ? (abus / bbus) : 8'h5A;

    divide_issue_stage #(.WIDTH(8), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .abus(abus), .bbus(bbus), .div_out(div_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_dz(res_dz),
        .dbg_state_o(dbg_state)
    );

    // WIDTH=1, SETTLE=1 instance
    logic v1, r1, a1, b1, ab1, bb1, do1, rv1, rr1, rq1, rd1;
    logic [1:0] dbg1;
    assign do1 = bb1 ? (ab1 / bb1) : 1'b0;

    divide_issue_stage #(.WIDTH(1), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
        .abus(ab1), .bbus(bb1), .div_out(do1),
        .res_valid(rv1), .res_ready(rr1), .res_q(rq1), .res_dz(rd1),
        .dbg_state_o(dbg1)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] pa_q[$];
    logic [7:0] pb_q[$];
    logic [8:0] exp_q[$];   // {dz, quotient}
    int         stamp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_now(input logic [7:0] a, input logic [7:0] b, input string tag);
        in_valid = 1'b1; in_a = a; in_b = b;
        check({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Streams pa_q/pb_q in and checks each handshaken result against exp_q.
    task automatic run(input int budget, input string tag);
        int n = 0;
        logic accept;
        logic [8:0] e;
        while ((pa_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            if (pa_q.size() != 0) begin
                in_valid = 1'b1; in_a = pa_q[0]; in_b = pb_q[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            accept = in_valid && in_ready;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_result"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_res_q"}, res_q, e[7:0]);
                    check({tag, "_res_dz"}, res_dz, e[8]);
                    stamp_q.push_back(cyc);
                end
            end
            step();
            if (accept) begin
                void'(pa_q.pop_front());
                void'(pb_q.pop_front());
            end
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_drained"}, pa_q.size() + exp_q.size(), 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic eq, input logic edz, input string tag);
        v1 = 1'b1; a1 = a; b1 = b;
        check({tag, "_in_ready"}, r1, 1);
        step();
        v1 = 1'b0;
        step();
        check({tag, "_valid_early"}, rv1, 0);
        step();
        check({tag, "_valid"}, rv1, 1);
        check({tag, "_res_q"}, rq1, eq);
        check({tag, "_res_dz"}, rd1, edz);
        step();
        check({tag, "_valid_drop"}, rv1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; rr1 = 1'b1;
        @(negedge clk);
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_q", res_q, 0);
        check("rst_res_dz", res_dz, 0);
        check("rst_abus", abus, 0);
        check("rst_bbus", bbus, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        step();

        // 100/7 with exact latency
        push_now(8'd100, 8'd7, "d100_7");
        check("d100_7_abus_pre", abus, 0);
        step();
        check("d100_7_abus", abus, 100);
        check("d100_7_bbus", bbus, 7);
        check("d100_7_valid_e1", res_valid, 0);
        step();
        check("d100_7_valid_e2", res_valid, 0);
        step();
        check("d100_7_valid_e3", res_valid, 1);
        check("d100_7_res_q", res_q, 14);
        check("d100_7_res_dz", res_dz, 0);
        step();
        check("d100_7_valid_e4", res_valid, 0);

        // 200/0 divide-by-zero
        push_now(8'd200, 8'd0, "dz");
        step(); step(); step();
        check("dz_valid", res_valid, 1);
        check("dz_res_q", res_q, 8'hFF);
        check("dz_res_dz", res_dz, 1);
        check("dz_abus", abus, 200);
        check("dz_bbus", bbus, 0);
        step();
        check("dz_valid_drop", res_valid, 0);
        step(); step();
        check("dz_abus_held", abus, 200);
        check("dz_bbus_held", bbus, 0);

        // Backpressure: three accepted, fourth stalls
        res_ready = 1'b0;
        push_now(8'd9, 8'd3, "bp9");
        push_now(8'd8, 8'd2, "bp8");
        push_now(8'd7, 8'd1, "bp7");
        check("bp_full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_a = 8'd6; in_b = 8'd6;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check("bp_hold_valid", res_valid, 1);
        check("bp_hold_res_q", res_q, 3);
        step();
        check("bp_hold_res_q2", res_q, 3);
        res_ready = 1'b1;
        pa_q.push_back(8'd6); pb_q.push_back(8'd6);
        exp_q.push_back({1'b0, 8'd3});
        exp_q.push_back({1'b0, 8'd4});
        exp_q.push_back({1'b0, 8'd7});
        exp_q.push_back({1'b0, 8'd1});
        run(80, "bp");

        // Reset during WAIT of 50/5
        push_now(8'd50, 8'd5, "rw");
        step();
        check("rw_state_wait", dbg_state, 1);
        check("rw_abus", abus, 50);
        rst_n = 1'b0;
        step();
        check("rw_abus_rst", abus, 0);
        check("rw_bbus_rst", bbus, 0);
        check("rw_valid_rst", res_valid, 0);
        check("rw_res_q_rst", res_q, 0);
        check("rw_res_dz_rst", res_dz, 0);
        check("rw_in_ready_rst", in_ready, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rw_no_result", res_valid, 0);
        end
        pa_q.push_back(8'd30); pb_q.push_back(8'd4);
        exp_q.push_back({1'b0, 8'd7});
        run(40, "rw_next");

        // Continuous stream: ordering and spacing
        stamp_q.delete();
        pa_q = '{8'd255, 8'd17, 8'd0, 8'd128, 8'd99, 8'd77, 8'd64, 8'd250};
        pb_q = '{8'd1,   8'd5,  8'd9, 8'd128, 8'd10, 8'd0,  8'd8,  8'd3};
        exp_q = '{{1'b0, 8'd255}, {1'b0, 8'd3}, {1'b0, 8'd0}, {1'b0, 8'd1},
                  {1'b0, 8'd9},   {1'b1, 8'hFF}, {1'b0, 8'd8}, {1'b0, 8'd83}};
        run(120, "stream");
        check("stream_count", stamp_q.size(), 8);
        for (int i = 1; i < stamp_q.size(); i++) begin
            check("stream_spacing", stamp_q[i] - stamp_q[i-1], 4);
        end

        // WIDTH=1, SETTLE=1
        op1(1'b1, 1'b1, 1'b1, 1'b0, "w1_1_1");
        op1(1'b0, 1'b1, 1'b0, 1'b0, "w1_0_1");
        op1(1'b1, 1'b0, 1'b1, 1'b1, "w1_1_0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
